// File: rtl/axi_lite_master_bridge.sv
// Bridges a single-outstanding CPU request/response port onto an AXI4-Lite master.
// One FSM sequences AR/R or AW/W/B; R and B waits are optionally bounded by MAX_WAIT.
module axi_lite_master_bridge #(
    parameter int unsigned MAX_WAIT = 1024
) (
    input  logic        aclk,
    input  logic        areset,
    // CPU request/response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // AXI4-Lite read
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // AXI4-Lite write
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdAddr = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrReq  = 3'd3;
    localparam logic [2:0] StWrResp = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam logic [31:0] WaitLast = 32'(MAX_WAIT - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] wait_q, wait_d;

    logic timeout_hit;
    logic aw_done;
    logic w_done;
    logic unused_resp_lsb;

    assign timeout_hit = (MAX_WAIT != 0) && (wait_q == WaitLast);
    // A channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_done     = !awvalid_q || awready;
    assign w_done      = !wvalid_q || wready;
    assign unused_resp_lsb = rresp[0] ^ bresp[0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wait_d       = wait_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_write) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdAddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StRdAddr: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wait_d    = '0;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = rdata;
                    resp_err_d   = rresp[1];
                    state_d      = StDone;
                end else if (timeout_hit) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = StDone;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StWrReq: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    wait_d   = '0;
                    state_d  = StWrResp;
                end
            end
            StWrResp: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = bresp[1];
                    state_d      = StDone;
                end else if (timeout_hit) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = StDone;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            wait_q       <= wait_d;
        end
    end

    // Gated by areset so the port is low throughout reset yet high on the first free cycle.
    assign req_ready  = (state_q == StIdle) && !areset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign arprot     = 3'b000;
    assign awprot     = 3'b000;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awvalid    = awvalid_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench: a reactive scripted slave plus a cycle-window model derived from the
// transaction's scripted latencies; one compare process checks every output each cycle.
module tb_axi_lite_master_bridge;

    localparam int MaxWait = 8;
    localparam int None    = -1000;

    logic        aclk;
    logic        areset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arprot, awprot;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;

    axi_lite_master_bridge #(.MAX_WAIT(MaxWait)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rst_seen = 0;
    bit started = 0;

    // Script of the transaction being issued (read by the model at acceptance).
    bit          cur_write;
    logic [31:0] cur_addr, cur_wdata, cur_rdata;
    logic [3:0]  cur_wstrb;
    logic [1:0]  cur_resp;
    int          cur_a_lat, cur_w_lat, cur_lat2, cur_hold;

    // Model: cycle windows of the outstanding transaction.
    bit          m_rd = 0;
    bit          m_to;
    int          m_acc = None, m_ar_hs = None, m_aw_hs = None, m_w_hs = None, m_both = None;
    int          m_end = None, m_resp_last = None;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_err;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        cyc      <= cyc + 1;
        rst_seen <= areset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    function automatic bit win(input int lo, input int hi);
        return (cyc >= lo) && (cyc <= hi);
    endfunction

    always @(negedge aclk) begin
        if (rst_seen) begin
            started = 1;
            m_acc = None; m_ar_hs = None; m_aw_hs = None; m_w_hs = None; m_both = None;
            m_end = None; m_resp_last = None;
            chk1("rst_resp_err", resp_err, 1'b0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_araddr", araddr, 32'h0);
            chk("rst_awaddr", awaddr, 32'h0);
            chk("rst_wdata", wdata, 32'h0);
            chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
        end
        if (started) begin
            chk1("req_ready", req_ready, !areset && !win(m_acc + 1, m_resp_last));
            chk1("arvalid", arvalid, m_rd && win(m_acc + 1, m_ar_hs));
            chk1("rready", rready, m_rd && win(m_ar_hs + 1, m_end));
            chk1("awvalid", awvalid, !m_rd && win(m_acc + 1, m_aw_hs));
            chk1("wvalid", wvalid, !m_rd && win(m_acc + 1, m_w_hs));
            chk1("bready", bready, !m_rd && win(m_both + 1, m_end));
            chk1("resp_valid", resp_valid, win(m_end + 1, m_resp_last));
            chk("arprot", {29'h0, arprot}, 32'h0);
            chk("awprot", {29'h0, awprot}, 32'h0);
            if (m_rd && win(m_acc + 1, m_ar_hs)) chk("araddr", araddr, m_addr);
            if (!m_rd && win(m_acc + 1, m_aw_hs)) chk("awaddr", awaddr, m_addr);
            if (!m_rd && win(m_acc + 1, m_w_hs)) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", {28'h0, wstrb}, {28'h0, m_wstrb});
            end
            if (win(m_end + 1, m_resp_last)) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk1("resp_err", resp_err, m_err);
            end
            if (req_valid && req_ready) begin
                m_acc = cyc; m_rd = !cur_write;
                m_addr = cur_addr; m_wdata = cur_wdata; m_wstrb = cur_wstrb;
                if (!cur_write) begin
                    m_ar_hs = cyc + 1 + cur_a_lat;
                    m_aw_hs = None; m_w_hs = None; m_both = None;
                    m_to    = cur_lat2 > MaxWait;
                    m_end   = m_to ? m_ar_hs + MaxWait : m_ar_hs + cur_lat2;
                    m_rdata = m_to ? 32'h0 : cur_rdata;
                end else begin
                    m_ar_hs = None;
                    m_aw_hs = cyc + 1 + cur_a_lat;
                    m_w_hs  = cyc + 1 + cur_w_lat;
                    m_both  = (m_aw_hs > m_w_hs) ? m_aw_hs : m_w_hs;
                    m_to    = cur_lat2 > MaxWait;
                    m_end   = m_to ? m_both + MaxWait : m_both + cur_lat2;
                    m_rdata = 32'h0;
                end
                m_err       = m_to || cur_resp[1];
                m_resp_last = m_end + 1 + cur_hold;
            end
        end
    end

    task automatic clear_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 0; arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Runs one transaction; called and returns at 1 time unit after a rising edge.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int a_lat, input int w_lat,
                           input int lat2, input logic [31:0] rd, input logic [1:0] rsp,
                           input int hold, output int lat, output logic [31:0] got_rdata,
                           output logic got_err);
        int a_seen = 0, w_seen = 0, rsp_seen = 0;
        int acc_cyc = 0, a_cyc = 0, w_cyc = 0, hs_cyc = 0, resp_cyc = 0;
        bit accepted = 0, a_done = 0, w_done = 0, d_done = 0, r_done = 0, resp_any = 0;
        cur_write = wr; cur_addr = addr; cur_wdata = wd; cur_wstrb = ws;
        cur_a_lat = a_lat; cur_w_lat = w_lat; cur_lat2 = lat2; cur_rdata = rd;
        cur_resp = rsp; cur_hold = hold;
        lat = -1; got_rdata = '0; got_err = 1'b0;
        for (int t = 0; t < 80 && !r_done; t++) begin
            req_valid = !accepted; req_write = wr; req_addr = addr;
            req_wdata = wd; req_wstrb = ws;
            arready = !wr && (a_seen >= a_lat);
            awready = wr && (a_seen >= a_lat);
            wready  = wr && (w_seen >= w_lat);
            rvalid  = !wr && a_done && !d_done && (cyc >= hs_cyc + lat2);
            bvalid  = wr && a_done && w_done && !d_done && (cyc >= hs_cyc + lat2);
            rdata = rd; rresp = rsp; bresp = rsp;
            resp_ready = (rsp_seen >= hold);
            @(negedge aclk);
            if (req_valid && req_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (!wr) begin
                if (arvalid && !a_done) begin
                    if (arready) begin a_done = 1; hs_cyc = cyc; end
                    a_seen++;
                end
                if (rvalid && rready) d_done = 1;
            end else begin
                if (awvalid && !a_done) begin
                    if (awready) begin a_done = 1; a_cyc = cyc; end
                    a_seen++;
                end
                if (wvalid && !w_done) begin
                    if (wready) begin w_done = 1; w_cyc = cyc; end
                    w_seen++;
                end
                if (a_done && w_done) hs_cyc = (a_cyc > w_cyc) ? a_cyc : w_cyc;
                if (bvalid && bready) d_done = 1;
            end
            if (resp_valid) begin
                if (!resp_any) begin resp_any = 1; resp_cyc = cyc; end
                if (resp_ready) begin
                    r_done = 1; got_rdata = resp_rdata; got_err = resp_err;
                end
                rsp_seen++;
            end
            @(posedge aclk);
            #1;
        end
        clear_inputs();
        chk1("txn_completes", r_done, 1'b1);
        if (accepted && resp_any) lat = resp_cyc - acc_cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] gd;
        logic        ge;
        clear_inputs();
        areset = 1;
        idle(3);
        @(negedge aclk);
        chk1("reset_req_ready_low", req_ready, 1'b0);
        chk1("reset_arvalid_low", arvalid, 1'b0);
        @(posedge aclk);
        #1;
        areset = 0;
        @(negedge aclk);
        chk1("req_ready_after_reset", req_ready, 1'b1);
        @(posedge aclk);
        #1;

        // Zero-wait read: accept 0, AR 1, R 2, resp 3.
        run_txn(0, 32'h1000_0004, 0, 0, 0, 0, 1, 32'hA5A5_0001, 2'b00, 0, lat, gd, ge);
        chk("rd_min_lat", lat, 3);
        chk("rd_min_rdata", gd, 32'hA5A5_0001);
        idle(2);
        // arready one cycle late, rvalid 5 cycles after AR.
        run_txn(0, 32'h0000_0020, 0, 0, 1, 0, 5, 32'hDEAD_BEEF, 2'b00, 0, lat, gd, ge);
        chk("rd_slow_lat", lat, 8);
        chk("rd_slow_rdata", gd, 32'hDEAD_BEEF);
        chk1("rd_slow_err", ge, 1'b0);
        idle(1);
        // W handshakes three cycles before AW.
        run_txn(1, 32'h10, 32'h1234_5678, 4'hF, 3, 0, 1, 0, 2'b00, 0, lat, gd, ge);
        chk("wr_w_first_lat", lat, 6);
        chk1("wr_w_first_err", ge, 1'b0);
        chk("wr_w_first_rdata", gd, 32'h0);
        // AW and W together, immediate B.
        run_txn(1, 32'h44, 32'hCAFE_F00D, 4'h3, 0, 0, 1, 0, 2'b00, 0, lat, gd, ge);
        chk("wr_fast_lat", lat, 3);
        // SLVERR read, response held off two cycles.
        run_txn(0, 32'h88, 0, 0, 0, 0, 2, 32'h0BAD_0BAD, 2'b10, 2, lat, gd, ge);
        chk1("rd_slverr_err", ge, 1'b1);
        chk("rd_slverr_lat", lat, 4);
        // DECERR write, W before AW, slow B.
        run_txn(1, 32'h90, 32'h0F0F_0F0F, 4'h5, 2, 1, 3, 0, 2'b11, 0, lat, gd, ge);
        chk1("wr_decerr_err", ge, 1'b1);
        chk("wr_decerr_lat", lat, 7);
        // EXOKAY write, AW before W.
        run_txn(1, 32'h94, 32'h7777_0000, 4'hC, 0, 2, 1, 0, 2'b01, 0, lat, gd, ge);
        chk1("wr_exokay_err", ge, 1'b0);
        chk("wr_exokay_lat", lat, 5);
        // Read timeout: RD_DATA entered at cycle 2, resp_valid 8 cycles later.
        run_txn(0, 32'hA0, 0, 0, 0, 0, 1000, 32'h1111_1111, 2'b00, 0, lat, gd, ge);
        chk("rd_timeout_lat", lat, 10);
        chk1("rd_timeout_err", ge, 1'b1);
        chk("rd_timeout_rdata", gd, 32'h0);
        // Write timeout on B.
        run_txn(1, 32'hA4, 32'h2222_2222, 4'hF, 0, 0, 1000, 0, 2'b00, 0, lat, gd, ge);
        chk("wr_timeout_lat", lat, 10);
        chk1("wr_timeout_err", ge, 1'b1);
        // rvalid arrives on the last waiting cycle: handshake beats the timeout.
        run_txn(0, 32'hA8, 0, 0, 0, 0, 8, 32'h0000_1234, 2'b01, 0, lat, gd, ge);
        chk("rd_edge_lat", lat, 10);
        chk("rd_edge_rdata", gd, 32'h0000_1234);
        chk1("rd_edge_err", ge, 1'b0);
        idle(2);

        // Reset during RD_DATA, then a late R beat that must be ignored.
        cur_write = 0; cur_addr = 32'hB0; cur_wdata = '0; cur_wstrb = '0;
        cur_a_lat = 0; cur_w_lat = 0; cur_lat2 = 1000; cur_rdata = '0;
        cur_resp = 2'b00; cur_hold = 0;
        req_valid = 1; req_write = 0; req_addr = 32'hB0; arready = 1; resp_ready = 1;
        @(negedge aclk);
        chk1("abort_accept", req_ready, 1'b1);
        idle(1);
        req_valid = 0;
        idle(2);
        areset = 1;
        idle(2);
        areset = 0; rvalid = 1; rdata = 32'h5555_AAAA;
        @(negedge aclk);
        chk1("abort_req_ready", req_ready, 1'b1);
        chk1("abort_rready", rready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            #1;
            @(negedge aclk);
            chk1("abort_no_resp", resp_valid, 1'b0);
        end
        @(posedge aclk);
        #1;
        clear_inputs();
        idle(1);

        // Recovery read after the abort.
        run_txn(0, 32'hC0, 0, 0, 2, 0, 3, 32'h600D_F00D, 2'b00, 1, lat, gd, ge);
        chk("rd_recover_lat", lat, 7);
        chk("rd_recover_rdata", gd, 32'h600D_F00D);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
